// File: rtl/jt900h_flags_pkg.sv
// Shared definitions for the flag register stage: F bit positions, carry
// source encodings, condition codes and the per-flag commit helper.
package jt900h_flags_pkg;

    localparam int SF_BIT = 7;
    localparam int ZF_BIT = 6;
    localparam int HF_BIT = 4;
    localparam int VF_BIT = 2;
    localparam int NF_BIT = 1;
    localparam int CF_BIT = 0;

    // Mask of the F positions that hold flags; positions 5 and 3 read as 0
    localparam logic [7:0] F_USED = 8'hD7;

    localparam logic [2:0] ALU_CF = 3'd0;
    localparam logic [2:0] SET_CF = 3'd1;
    localparam logic [2:0] CLR_CF = 3'd2;
    localparam logic [2:0] CPL_CF = 3'd3;
    localparam logic [2:0] NZ_CF  = 3'd4;

    localparam logic [3:0] CC_F   = 4'h0;
    localparam logic [3:0] CC_LT  = 4'h1;
    localparam logic [3:0] CC_LE  = 4'h2;
    localparam logic [3:0] CC_ULE = 4'h3;
    localparam logic [3:0] CC_OV  = 4'h4;
    localparam logic [3:0] CC_MI  = 4'h5;
    localparam logic [3:0] CC_Z   = 4'h6;
    localparam logic [3:0] CC_C   = 4'h7;
    localparam logic [3:0] CC_T   = 4'h8;
    localparam logic [3:0] CC_GE  = 4'h9;
    localparam logic [3:0] CC_GT  = 4'hA;
    localparam logic [3:0] CC_UGT = 4'hB;
    localparam logic [3:0] CC_NOV = 4'hC;
    localparam logic [3:0] CC_PL  = 4'hD;
    localparam logic [3:0] CC_NZ  = 4'hE;
    localparam logic [3:0] CC_NC  = 4'hF;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    // One flag-write request: mask {S,Z,H,V,N,C} plus its source selects
    typedef struct packed {
        logic [5:0] we;
        logic       vp_sel;
        logic       n_set;
        logic [2:0] c_op;
    } flag_req_t;

    // Apply a write request on top of 'base'; CPL/NZ carry sources read 'cur'
    function automatic logic [7:0] apply_flags(
        input logic [7:0] base,
        input logic [7:0] cur,
        input flag_req_t  req,
        input logic       s, z, p, c, v, h
    );
        logic [7:0] r;
        logic       c_new;
        r = base;
        case (req.c_op)
            SET_CF:  c_new = 1'b1;
            CLR_CF:  c_new = 1'b0;
            CPL_CF:  c_new = ~cur[CF_BIT];
            NZ_CF:   c_new = ~cur[ZF_BIT];
            default: c_new = c;
        endcase
        if (req.we[5]) r[SF_BIT] = s;
        if (req.we[4]) r[ZF_BIT] = z;
        if (req.we[3]) r[HF_BIT] = h;
        if (req.we[2]) r[VF_BIT] = req.vp_sel ? p : v;
        if (req.we[1]) r[NF_BIT] = req.n_set;
        if (req.we[0]) r[CF_BIT] = c_new;
        return r & F_USED;
    endfunction

endpackage

// File: rtl/jt900h_flags_cc.sv
// Combinational condition-code decoder: F and a 4-bit cc give cc_ok.
module jt900h_flags_cc
    import jt900h_flags_pkg::*;
(
    input  logic [7:0] f,
    input  logic [3:0] cc,
    output logic       cc_ok
);
    logic s, z, v, c, lt, cond;
    logic unused_f;

    assign s  = f[SF_BIT];
    assign z  = f[ZF_BIT];
    assign v  = f[VF_BIT];
    assign c  = f[CF_BIT];
    assign lt = s ^ v;
    assign unused_f = ^{f[5], f[HF_BIT], f[3], f[NF_BIT]};

    // Upper half of the table is the complement of the lower half
    always_comb begin
        case (cc[2:0])
            CC_F[2:0]:   cond = 1'b0;
            CC_LT[2:0]:  cond = lt;
            CC_LE[2:0]:  cond = lt | z;
            CC_ULE[2:0]: cond = c | z;
            CC_OV[2:0]:  cond = v;
            CC_MI[2:0]:  cond = s;
            CC_Z[2:0]:   cond = z;
            default:     cond = c;
        endcase
        cc_ok = cond ^ cc[3];
    end
endmodule

// File: rtl/jt900h_flags.sv
// Flag register F and shadow F': commits ALU flags under per-flag control,
// supports deferred commits during division, and resolves condition codes.
module jt900h_flags
    import jt900h_flags_pkg::*;
#(
    parameter logic [7:0] FRST = 8'h00
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       alu_s,
    input  logic       alu_z,
    input  logic       alu_p,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       alu_h,
    input  logic [5:0] flag_we,
    input  logic       vp_sel,
    input  logic       n_set,
    input  logic [2:0] c_op,
    input  logic       defer,
    input  logic       div_busy,
    input  logic       f_ld,
    input  logic [7:0] f_din,
    input  logic       ex_ff,
    input  logic [3:0] cc,
    output logic [7:0] flags,
    output logic [7:0] flags_alt,
    output logic       nin,
    output logic       hin,
    output logic       cin,
    output logic       zin,
    output logic       cc_ok,
    output logic       busy
);
    state_t     state_q, state_d;
    logic [7:0] f_q, f_d, alt_q, alt_d, base;
    flag_req_t  pend_q, pend_d, req_in;
    logic       unused_din;

    assign req_in     = '{we: flag_we, vp_sel: vp_sel, n_set: n_set, c_op: c_op};
    assign unused_din = ^{f_din[5], f_din[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cen) begin
            case (state_q)
                ST_IDLE: if (!f_ld && flag_we != 6'd0 && defer) state_d = ST_WAIT;
                ST_WAIT: if (!div_busy) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_WAIT);
    end

    // A swap picks F' as the base onto which any load or commit is applied
    always_comb begin
        f_d    = f_q;
        alt_d  = alt_q;
        pend_d = pend_q;
        base   = ex_ff ? alt_q : f_q;
        if (cen) begin
            f_d = base;
            if (ex_ff) alt_d = f_q;
            case (state_q)
                ST_IDLE: begin
                    if (f_ld) begin
                        f_d = f_din & F_USED;
                    end else if (flag_we != 6'd0) begin
                        if (defer) pend_d = req_in;
                        else f_d = apply_flags(base, f_q, req_in,
                                               alu_s, alu_z, alu_p, alu_c, alu_v, alu_h);
                    end
                end
                ST_WAIT: begin
                    if (!div_busy)
                        f_d = apply_flags(base, f_q, pend_q,
                                          alu_s, alu_z, alu_p, alu_c, alu_v, alu_h);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q    <= FRST & F_USED;
            alt_q  <= FRST & F_USED;
            pend_q <= '0;
        end else begin
            f_q    <= f_d;
            alt_q  <= alt_d;
            pend_q <= pend_d;
        end
    end

    assign flags     = f_q;
    assign flags_alt = alt_q;
    assign nin       = f_q[NF_BIT];
    assign hin       = f_q[HF_BIT];
    assign cin       = f_q[CF_BIT];
    assign zin       = f_q[ZF_BIT];

    jt900h_flags_cc u_cc (
        .f     (f_q),
        .cc    (cc),
        .cc_ok (cc_ok)
    );
endmodule

// File: tb/tb_jt900h_flags.sv
// Self-checking bench for jt900h_flags: directed sequences, a cc table and
// randomized traffic against a flag-level reference model.
module tb_jt900h_flags;
    logic       clk = 1'b0;
    logic       rst_n, cen;
    logic       alu_s, alu_z, alu_p, alu_c, alu_v, alu_h;
    logic [5:0] flag_we;
    logic       vp_sel, n_set, defer, div_busy, f_ld, ex_ff;
    logic [2:0] c_op;
    logic [7:0] f_din;
    logic [3:0] cc;
    logic [7:0] flags, flags_alt;
    logic       nin, hin, cin, zin, cc_ok, busy;

    int n_pass  = 0;
    int n_total = 0;

    jt900h_flags #(.FRST(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .alu_s(alu_s), .alu_z(alu_z), .alu_p(alu_p), .alu_c(alu_c),
        .alu_v(alu_v), .alu_h(alu_h),
        .flag_we(flag_we), .vp_sel(vp_sel), .n_set(n_set), .c_op(c_op),
        .defer(defer), .div_busy(div_busy), .f_ld(f_ld), .f_din(f_din),
        .ex_ff(ex_ff), .cc(cc),
        .flags(flags), .flags_alt(flags_alt),
        .nin(nin), .hin(hin), .cin(cin), .zin(zin),
        .cc_ok(cc_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic [3:0] cc;
        logic       exp_ok;
    } cc_vec_t;

    // Reference model state
    logic [7:0] m_f, m_alt;
    logic       m_pend, m_vps, m_ns;
    logic [5:0] m_we;
    logic [2:0] m_cop;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic quiet();
        cen = 1'b1; flag_we = 6'd0; vp_sel = 1'b0; n_set = 1'b0; c_op = 3'd0;
        defer = 1'b0; div_busy = 1'b0; f_ld = 1'b0; f_din = 8'h00; ex_ff = 1'b0;
        cc = 4'h0;
        {alu_s, alu_z, alu_p, alu_c, alu_v, alu_h} = 6'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_f(input logic [7:0] v);
        f_ld = 1'b1; f_din = v;
        tick();
        f_ld = 1'b0;
    endtask

    // Condition truth straight from the cc table, written out per code
    function automatic logic model_cc(input logic [7:0] f, input logic [3:0] code);
        logic s, z, v, c;
        s = f[7]; z = f[6]; v = f[2]; c = f[0];
        case (code)
            4'h0: return 1'b0;
            4'h1: return s != v;
            4'h2: return (s != v) || z;
            4'h3: return c || z;
            4'h4: return v;
            4'h5: return s;
            4'h6: return z;
            4'h7: return c;
            4'h8: return 1'b1;
            4'h9: return s == v;
            4'hA: return !((s != v) || z);
            4'hB: return !(c || z);
            4'hC: return !v;
            4'hD: return !s;
            4'hE: return !z;
            default: return !c;
        endcase
    endfunction

    function automatic logic [7:0] model_commit(input logic [7:0] onto, input logic [7:0] cur,
                                                input logic [5:0] we, input logic vps,
                                                input logic ns, input logic [2:0] cop);
        logic [7:0] r;
        logic       cv;
        r = onto;
        if (cop == 3'd1)      cv = 1'b1;
        else if (cop == 3'd2) cv = 1'b0;
        else if (cop == 3'd3) cv = !cur[0];
        else if (cop == 3'd4) cv = !cur[6];
        else                  cv = alu_c;
        if (we[5]) r[7] = alu_s;
        if (we[4]) r[6] = alu_z;
        if (we[3]) r[4] = alu_h;
        if (we[2]) r[2] = vps ? alu_p : alu_v;
        if (we[1]) r[1] = ns;
        if (we[0]) r[0] = cv;
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [7:0] onto, nf, nalt;
        if (!cen) return;
        onto = ex_ff ? m_alt : m_f;
        nalt = ex_ff ? m_f : m_alt;
        nf   = onto;
        if (m_pend) begin
            if (!div_busy) begin
                nf = model_commit(onto, m_f, m_we, m_vps, m_ns, m_cop);
                m_pend = 1'b0;
            end
        end else if (f_ld) begin
            nf = f_din & 8'hD7;
        end else if (flag_we != 0 && defer) begin
            m_pend = 1'b1; m_we = flag_we; m_vps = vp_sel; m_ns = n_set; m_cop = c_op;
        end else if (flag_we != 0) begin
            nf = model_commit(onto, m_f, flag_we, vp_sel, n_set, c_op);
        end
        m_f = nf;
        m_alt = nalt;
    endtask

    cc_vec_t cc_tab[$];

    initial begin
        quiet();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        #4;

        // Reset state
        check("reset_flags", flags, 8'h00);
        check("reset_alt", flags_alt, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);

        // Full-mask commit
        flag_we = 6'h3F; alu_s = 1; alu_z = 0; alu_h = 1; alu_v = 1; alu_c = 1; n_set = 1;
        tick();
        quiet();
        $display("full-mask commit: flags=%h", flags);
        check("commit_all", flags, 8'h97);
        cc = 4'h1; #1 check("cc_lt_97", {7'd0, cc_ok}, 8'h00);
        cc = 4'h7; #1 check("cc_c_97", {7'd0, cc_ok}, 8'h01);
        check("nin_hin_cin_zin", {4'd0, nin, hin, cin, zin}, 8'h0E);

        // Carry operations and clock enable
        load_f(8'h41);
        flag_we = 6'h01; c_op = 3'd4; tick();
        $display("ZCF: flags=%h", flags);
        check("c_nz", flags, 8'h40);
        c_op = 3'd3; tick();
        $display("CCF: flags=%h", flags);
        check("c_cpl", flags, 8'h41);
        cen = 1'b0; flag_we = 6'h3F; f_ld = 1'b1; ex_ff = 1'b1; tick();
        quiet();
        check("cen_low_hold", flags, 8'h41);

        // Exchange with shadow
        load_f(8'hC0);
        ex_ff = 1'b1; f_ld = 1'b1; f_din = 8'h12; tick(); quiet();
        check("setup_f", flags, 8'h12);
        check("setup_alt", flags_alt, 8'hC0);
        ex_ff = 1'b1; tick(); quiet();
        $display("EX F,F': flags=%h alt=%h", flags, flags_alt);
        check("ex_f", flags, 8'hC0);
        check("ex_alt", flags_alt, 8'h12);
        ex_ff = 1'b1; f_ld = 1'b1; f_din = 8'hFF; tick(); quiet();
        check("ex_ld_f", flags, 8'hD7);
        check("ex_ld_alt", flags_alt, 8'hC0);
        ex_ff = 1'b1; flag_we = 6'h01; c_op = 3'd2; tick(); quiet();
        check("ex_we_f", flags, 8'hC0);
        check("ex_we_alt", flags_alt, 8'hD7);

        // Deferred commit held by the divider
        load_f(8'h00);
        defer = 1'b1; flag_we = 6'h04; div_busy = 1'b1; tick();
        defer = 1'b0; flag_we = 6'h00;
        for (int i = 0; i < 5; i++) begin
            check("wait_busy", {7'd0, busy}, 8'h01);
            check("wait_hold", flags, 8'h00);
            f_ld = 1'b1; f_din = 8'hFF; flag_we = 6'h3F; alu_v = 1'b1;
            tick();
        end
        quiet();
        alu_v = 1'b1;
        tick(); quiet();
        $display("deferred commit: flags=%h busy=%0d", flags, busy);
        check("defer_commit", flags, 8'h04);
        check("defer_done", {7'd0, busy}, 8'h00);

        // Deferred with divider already idle: two-cycle latency
        flag_we = 6'h20; defer = 1'b1; alu_s = 1'b1; tick();
        quiet(); alu_s = 1'b1;
        check("defer_fast_hold", flags, 8'h04);
        tick(); quiet();
        check("defer_fast_commit", flags, 8'h84);

        // Async reset mid-wait discards the pending update
        load_f(8'hFF);
        defer = 1'b1; flag_we = 6'h3F; div_busy = 1'b1; tick();
        quiet(); div_busy = 1'b1;
        check("rst_pre_busy", {7'd0, busy}, 8'h01);
        rst_n = 1'b0; #1;
        check("rst_async_f", flags, 8'h00);
        check("rst_async_alt", flags_alt, 8'h00);
        check("rst_async_busy", {7'd0, busy}, 8'h00);
        #3 rst_n = 1'b1;
        div_busy = 1'b0; {alu_s, alu_z, alu_p, alu_c, alu_v, alu_h} = 6'h3F;
        tick(); tick(); quiet();
        check("rst_no_commit", flags, 8'h00);

        // cc table
        cc_tab = '{
            '{8'h00, 4'h0, 1'b0}, '{8'h00, 4'h8, 1'b1}, '{8'h00, 4'h2, 1'b0},
            '{8'h00, 4'h9, 1'b1}, '{8'h04, 4'h1, 1'b1}, '{8'h04, 4'h4, 1'b1},
            '{8'h04, 4'hC, 1'b0}, '{8'h40, 4'h2, 1'b1}, '{8'h40, 4'h6, 1'b1},
            '{8'h40, 4'hE, 1'b0}, '{8'h40, 4'h3, 1'b1}, '{8'h80, 4'h5, 1'b1},
            '{8'h80, 4'h1, 1'b1}, '{8'h80, 4'h9, 1'b0}, '{8'h84, 4'h1, 1'b0},
            '{8'h84, 4'hA, 1'b1}, '{8'h84, 4'h2, 1'b0}, '{8'h01, 4'h7, 1'b1},
            '{8'h01, 4'hB, 1'b0}, '{8'h01, 4'hF, 1'b0}, '{8'h01, 4'h3, 1'b1},
            '{8'h84, 4'hD, 1'b0}
        };
        foreach (cc_tab[i]) begin
            load_f(cc_tab[i].f);
            cc = cc_tab[i].cc; #1;
            $display("cc vec %0d: F=%h cc=%h cc_ok=%0d", i, cc_tab[i].f, cc, cc_ok);
            check("cc_table", {7'd0, cc_ok}, {7'd0, cc_tab[i].exp_ok});
        end

        // Randomized traffic against the model
        quiet();
        rst_n = 1'b0; #2 rst_n = 1'b1;
        m_f = 8'h00; m_alt = 8'h00; m_pend = 1'b0;
        m_we = 6'd0; m_vps = 1'b0; m_ns = 1'b0; m_cop = 3'd0;
        tick();
        for (int t = 0; t < 600; t++) begin
            cen      = ($urandom_range(0, 7) != 0);
            {alu_s, alu_z, alu_p, alu_c, alu_v, alu_h} = 6'($urandom);
            flag_we  = ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'd0;
            vp_sel   = 1'($urandom);
            n_set    = 1'($urandom);
            c_op     = 3'($urandom);
            defer    = ($urandom_range(0, 3) == 0);
            div_busy = ($urandom_range(0, 2) != 0);
            f_ld     = ($urandom_range(0, 5) == 0);
            f_din    = 8'($urandom);
            ex_ff    = ($urandom_range(0, 5) == 0);
            cc       = 4'($urandom);
            // Keep swap-plus-commit cycles clear of carry ops that read F
            if (ex_ff && flag_we[0] && (c_op == 3'd3 || c_op == 3'd4)) c_op = 3'd1;
            if (ex_ff && m_pend && m_we[0] && (m_cop == 3'd3 || m_cop == 3'd4)) ex_ff = 1'b0;
            #1;
            check("rnd_cc_ok", {7'd0, cc_ok}, {7'd0, model_cc(m_f, cc)});
            model_step();
            tick();
            if (t % 50 == 0) $display("random txn %0d: flags=%h alt=%h busy=%0d", t, flags, flags_alt, busy);
            check("rnd_flags", flags, m_f);
            check("rnd_alt", flags_alt, m_alt);
            check("rnd_busy", {7'd0, busy}, {7'd0, m_pend});
            check("rnd_feedback", {4'd0, nin, hin, cin, zin}, {4'd0, m_f[1], m_f[4], m_f[0], m_f[6]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule
